// File: rtl/uart_tx_gen2_if.sv
// Byte-stream handshake into the UART transmitter: producer drives data/valid, transmitter drives ready.
interface uart_tx_gen2_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_gen2.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one or two stop bits.
// Frame settings and baud divisor are captured with the word, so a frame is immune to input changes.
module uart_tx_gen2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_gen2_if.slave        s,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 stop2,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [DIV_WIDTH-1:0]    cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tx_q;
  logic                    busy_q;

  logic                    bit_end_c;
  logic [IDX_W-1:0]        idx_nxt_c;

  // Current bit has lasted div_q+1 cycles when the counter reaches the divisor.
  assign bit_end_c = (cnt == div_q);
  assign idx_nxt_c = idx + IDX_W'(1);

  assign s.s_ready = (state == IDLE);
  assign tx_out    = tx_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      cnt       <= '0;
      idx       <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (s.s_valid) begin
            data_q    <= s.s_data;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            stop2_q   <= stop2;
            div_q     <= baud_div;
            cnt       <= '0;
            idx       <= '0;
            state     <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        START: begin
          if (bit_end_c) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx_q  <= data_q[0];
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_end_c) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= (^data_q) ^ par_typ_q;
              end else begin
                state <= STOP1;
                tx_q  <= 1'b1;
              end
            end else begin
              idx  <= idx_nxt_c;
              tx_q <= data_q[idx_nxt_c];
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end

        PARITY: begin
          if (bit_end_c) begin
            cnt   <= '0;
            state <= STOP1;
            tx_q  <= 1'b1;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end

        STOP1: begin
          if (bit_end_c) begin
            cnt <= '0;
            if (stop2_q) begin
              state <= STOP2;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end

        STOP2: begin
          if (bit_end_c) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Bench for uart_tx_gen2: an 8-bit and a 5-bit instance checked every cycle against a
// queue of expected line levels, plus hand-computed frames for the key cases.
module tb_uart_tx_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d8;
  logic       v8;
  logic [4:0] d5;
  logic       v5;
  logic       par_en, par_typ, stop2;
  logic [7:0] baud_div;
  logic       tx8, busy8, ready8;
  logic       tx5, busy5, ready5;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Expected line level for each upcoming cycle; empty means idle.
  logic q8[$];
  logic q5[$];

  always #5 clk = ~clk;

  uart_tx_gen2_if #(.DATA_WIDTH(8)) bus8 ();
  uart_tx_gen2_if #(.DATA_WIDTH(5)) bus5 ();

  assign bus8.s_data  = d8;
  assign bus8.s_valid = v8;
  assign ready8       = bus8.s_ready;
  assign bus5.s_data  = d5;
  assign bus5.s_valid = v5;
  assign ready5       = bus5.s_ready;

  uart_tx_gen2 #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s(bus8),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .baud_div(baud_div),
    .tx_out(tx8), .busy(busy8)
  );

  uart_tx_gen2 #(.DATA_WIDTH(5), .DIV_WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .s(bus5),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .baud_div(baud_div),
    .tx_out(tx5), .busy(busy5)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame bits in line order (bit 0 first); unused upper positions are idle-high.
  function automatic logic [15:0] frame_vec(input int w, input logic [8:0] d, input logic pe, input logic pt);
    logic [15:0] v;
    v    = '1;
    v[0] = 1'b0;
    for (int i = 0; i < w; i++) v[1+i] = d[i];
    if (pe) v[1+w] = (^d) ^ pt;
    return v;
  endfunction

  task automatic push_frame(input int w, input logic [8:0] d, input logic pe, input logic pt,
                            input logic s2, input logic [7:0] div);
    logic [15:0] v;
    int          n;
    v = frame_vec(w, d, pe, pt);
    n = 2 + w + int'(pe) + int'(s2);
    for (int b = 0; b < n; b++)
      for (int k = 0; k <= int'(div); k++)
        if (w == 8) q8.push_back(v[b]); else q5.push_back(v[b]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q8.delete();
      q5.delete();
    end else begin
      if (q8.size() != 0) void'(q8.pop_front());
      else if (v8) push_frame(8, {1'b0, d8}, par_en, par_typ, stop2, baud_div);
      if (q5.size() != 0) void'(q5.pop_front());
      else if (v5) push_frame(5, {4'b0, d5}, par_en, par_typ, stop2, baud_div);
    end
  end

  function automatic logic exp_tx(input int w);
    if (w == 8) return (q8.size() != 0) ? q8[0] : 1'b1;
    return (q5.size() != 0) ? q5[0] : 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("tx8",    16'(tx8),    16'(exp_tx(8)));
      chk("busy8",  16'(busy8),  16'(q8.size() != 0));
      chk("ready8", 16'(ready8), 16'(q8.size() == 0));
      chk("tx5",    16'(tx5),    16'(exp_tx(5)));
      chk("busy5",  16'(busy5),  16'(q5.size() != 0));
      chk("ready5", 16'(ready5), 16'(q5.size() == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, scramble all inputs once accepted, record the line until busy drops.
  task automatic send(input int w, input logic [8:0] d, input logic pe, input logic pt, input logic s2,
                      input logic [7:0] div, output logic [0:63] samp, output int n);
    logic t, b;
    if (w == 8) begin d8 = d[7:0]; v8 = 1'b1; end
    else        begin d5 = d[4:0]; v5 = 1'b1; end
    par_en = pe; par_typ = pt; stop2 = s2; baud_div = div;
    tick();
    v8 = 1'b0; v5 = 1'b0;
    d8 = ~d8; d5 = ~d5; par_en = ~pe; par_typ = ~pt; stop2 = ~s2; baud_div = ~div;
    samp = '1;
    n    = 0;
    for (int i = 0; i < 64; i++) begin
      t = (w == 8) ? tx8 : tx5;
      b = (w == 8) ? busy8 : busy5;
      samp[i] = t;
      if (!b) break;
      n++;
      tick();
    end
  endtask

  logic [0:63] samp;
  int          n;
  logic [0:21] tr, bz;
  int          rc;

  initial begin
    rst = 1'b1; d8 = '0; v8 = 1'b0; d5 = '0; v5 = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; baud_div = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_tx",    16'(tx8),    16'(1'b1));
    chk("reset_busy",  16'(busy8),  16'(1'b0));
    chk("reset_ready", 16'(ready8), 16'(1'b1));
    checking = 1'b1;
    tick();

    send(8, 9'h0A5, 1'b0, 1'b0, 1'b0, 8'd0, samp, n);
    chk("a5_frame", 16'(samp[0:9]), 16'(10'b0101001011));
    chk("a5_len",   16'(n), 16'd10);
    tick();

    send(8, 9'h003, 1'b1, 1'b0, 1'b0, 8'd0, samp, n);
    chk("par_even", 16'(samp[9]), 16'(1'b0));
    chk("par_len",  16'(n), 16'd11);
    send(8, 9'h003, 1'b1, 1'b1, 1'b0, 8'd0, samp, n);
    chk("par_odd",  16'(samp[9]), 16'(1'b1));

    send(8, 9'h0FF, 1'b1, 1'b0, 1'b1, 8'd3, samp, n);
    chk("div3_busy_len", 16'(n), 16'd48);
    chk("div3_start",    16'(samp[0:3]), 16'(4'b0000));
    chk("div3_d0",       16'(samp[4:7]), 16'(4'b1111));
    chk("div3_parity",   16'(samp[36:39]), 16'(4'b0000));
    chk("div3_stops",    16'(samp[40:47]), 16'(8'hFF));

    // Two words offered back to back with s_valid held high.
    d8 = 8'h5A; v8 = 1'b1; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; baud_div = 8'd0;
    tick();
    d8 = 8'h3C;
    rc = 0;
    for (int i = 0; i < 22; i++) begin
      tr[i] = tx8; bz[i] = busy8;
      if (i <= 20 && ready8) rc++;
      if (i == 11) v8 = 1'b0;
      tick();
    end
    chk("b2b_gap_tx",   16'(tr[10]), 16'(1'b1));
    chk("b2b_gap_busy", 16'(bz[10]), 16'(1'b0));
    chk("b2b_start2",   16'(tr[11]), 16'(1'b0));
    chk("b2b_ready_pulses", 16'(rc), 16'd1);

    // Abort during data bit 3.
    d8 = 8'hA5; v8 = 1'b1; par_en = 1'b0; stop2 = 1'b0; baud_div = 8'd0;
    tick();
    v8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx",    16'(tx8),    16'(1'b1));
    chk("abort_busy",  16'(busy8),  16'(1'b0));
    chk("abort_ready", 16'(ready8), 16'(1'b1));
    send(8, 9'h0C3, 1'b0, 1'b0, 1'b0, 8'd0, samp, n);
    chk("after_abort_frame", 16'(samp[0:9]), 16'(10'b0110000111));
    chk("after_abort_len",   16'(n), 16'd10);

    send(5, 9'h011, 1'b1, 1'b1, 1'b0, 8'd0, samp, n);
    chk("w5_frame", 16'(samp[0:7]), 16'(8'b01000111));
    chk("w5_len",   16'(n), 16'd8);

    // Random traffic, including input churn while busy and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      d8       = 8'($urandom);
      d5       = 5'($urandom);
      v8       = ($urandom % 4) == 0;
      v5       = ($urandom % 4) == 0;
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      stop2    = 1'($urandom);
      baud_div = (($urandom % 8) == 0) ? 8'($urandom_range(4, 9)) : 8'($urandom_range(0, 3));
      rst      = ($urandom % 150) == 0;
      tick();
    end
    rst = 1'b0; v8 = 1'b0; v5 = 1'b0;
    repeat (160) tick();
    chk("drain_idle8", 16'(busy8), 16'(1'b0));
    chk("drain_idle5", 16'(busy5), 16'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
